instr_encoder: RTL and testbench
================================

# instr_encoder

Field-to-word RV32I instruction encoder with output buffering, the inverse of the pipeline's instruction field decoder. It accepts decoded fields (opcode, rs1, rs2, rd, func3, func7, immediate) over a valid/ready handshake and packs them into 32-bit instruction words according to the opcode's format. Words are buffered in a small FIFO and emitted with a running instruction-memory byte address. It is used by the program loader / self-test path to write instruction memory without a host-side assembler.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in words (power of two, ≥2)
- AW, 32, address width

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: load address counter from base_addr
- base_addr  input  AW  start byte address (bits [1:0] ignored, forced 0)
- flush  input  1  discard all buffered words
- in_valid  input  1  field tuple valid
- in_ready  output  1  encoder can accept
- opcode  input  7  instr[6:0]
- rd  input  5  destination register
- rs1  input  5  source 1
- rs2  input  5  source 2
- func3  input  3  function 3
- func7  input  7  function 7
- imm  input  32  immediate, sign-extended value, interpreted per format
- out_valid  output  1  word available
- out_ready  input  1  consumer accepts word
- out_instr  output  32  encoded word
- out_addr  output  AW  byte address of out_instr
- err  output  1  one-cycle pulse: illegal opcode dropped (see Configuration)
- err_count  output  8  saturating count of dropped tuples

## Operation
- Formats by opcode: R 0110011; I 0010011, 0000011, 1100111, 1110011; S 0100011; B 1100011; U 0110111, 0010111; J 1101111.
- R: {func7, rs2, rs1, func3, rd, opcode}. I: {imm[11:0], rs1, func3, rd, opcode}.
- S: {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}; imm[0] ignored.
- U: {imm[31:12], rd, opcode}. J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Unused fields for a format are ignored, never OR-ed in.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Address counter: holds the address of the FIFO head word; +4 on every pop, wraps modulo 2^AW; start loads base_addr & ~3. start and pop in the same cycle: start wins.
- flush: empties FIFO next cycle, address counter unchanged, push in the same cycle is discarded; flush and start may coincide, both take effect.

## Timing
- Reset: FIFO empty, out_valid=0, in_ready=1, out_instr=0, out_addr=0, err=0, err_count=0.
- Latency: tuple accepted in cycle N → out_valid=1 with its word in cycle N+1 (empty FIFO).
- in_ready = !full (registered count); no same-cycle bypass of full by pop. Full: DEPTH words held, in_ready=0.
- Simultaneous push and pop when non-empty and non-full: count unchanged, order preserved.
- out_instr/out_addr stable while out_valid && !out_ready.
- Reset mid-stream: all buffered words lost, counters cleared, no partial output.

## Configuration
- INSTR_ENCODER_ILLEGAL_CHECK_EN defined: opcodes outside the list are accepted (in_ready honoured) but not pushed; err pulses the cycle after acceptance; err_count increments, saturating at 255.
- Undefined: unknown opcodes are encoded in R layout and pushed; err and err_count tied 0.

## Structure
- Shared package rv32_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL), format enum (FMT_R/I/S/B/U/J/BAD).
- Sub-module instr_fifo (DEPTH×32, count-based full/empty); packing logic combinational in the top.

## Test plan
- Push add x3,x1,x2 (op 0110011, rd3, rs1 1, rs2 2, f3 0, f7 0) after start base_addr=0x100 → out_instr 0x002081B3, out_addr 0x100, one cycle later.
- Push addi x1,x0,5 then sw x2,8(x1) (f3 010) → 0x00500093 @0x100, 0x0020A423 @0x104.
- beq x0,x0,imm=-4 → 0xFE000EE3; lui x5 imm=0x12345000 → 0x123452B7.
- Hold out_ready=0, push 5 tuples → in_ready drops after 4th, 5th waits; release → all 5 in order, addresses +4 each.
- flush with 3 words buffered → out_valid=0 next cycle, next push emitted at unchanged head address.
- With macro: opcode 0000000 → nothing emitted, err pulse, err_count=1; without: word emitted in R layout.

Source files
------------

// File: rtl/rv32_pkg.sv
// RV32I opcode constants and instruction-format classification shared by
// the instruction encoder and its FIFO.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  // Map an opcode to its encoding format; anything unlisted is FMT_BAD.
  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_R:                                 f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  f = FMT_I;
      OP_STORE:                             f = FMT_S;
      OP_BRANCH:                            f = FMT_B;
      OP_LUI, OP_AUIPC:                     f = FMT_U;
      OP_JAL:                               f = FMT_J;
      default:                              f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// DEPTH x 32 word FIFO with count-based full/empty and synchronous flush.
// dout reads 0 while empty so an idle output bus is quiet.
module instr_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;
  assign dout    = empty ? '0 : mem[rptr];

  // Pointer and occupancy bookkeeping; flush discards content and any same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Word storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into 32-bit instruction words, buffers them in
// instr_fifo and tags each output word with a running byte address.
// Optional macro INSTR_ENCODER_ILLEGAL_CHECK_EN drops unknown opcodes and
// reports them on err/err_count; otherwise they are packed in R layout.
module instr_encoder
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    opcode,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [2:0]    func3,
  input  logic [6:0]    func7,
  input  logic [31:0]   imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [AW-1:0] out_addr,
  output logic          err,
  output logic [7:0]    err_count
);

  fmt_e          fmt;
  logic [31:0]   word;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [AW-1:0] addr;
  logic          unused_base;

  assign unused_base = ^base_addr[1:0];
  assign fmt         = fmt_of(opcode);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign accept      = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign out_addr    = addr;

  // Select the bit layout for the opcode's format; fields a format does not use stay out.
  always_comb begin
    word = '0;
    case (fmt)
      FMT_I:   word = {imm[11:0], rs1, func3, rd, opcode};
      FMT_S:   word = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
      FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
      FMT_U:   word = {imm[31:12], rd, opcode};
      FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = {func7, rs2, rs1, func3, rd, opcode};
    endcase
  end

  instr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (push),
    .pop  (pop),
    .din  (word),
    .dout (out_instr),
    .full (full),
    .empty(empty)
  );

  // Head-word address: start reloads (word aligned) and beats a pop; a pop under
  // flush is discarded by the FIFO, so the address does not advance either.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (start) begin
      addr <= {base_addr[AW-1:2], 2'b00};
    end else if (pop && !flush) begin
      addr <= addr + AW'(4);
    end
  end

`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
  logic bad;

  assign bad  = accept && (fmt == FMT_BAD);
  assign push = accept && (fmt != FMT_BAD);

  // Unknown opcodes are consumed but dropped; flag each one and keep a saturating tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= bad;
      if (bad && (err_count != 8'hFF)) err_count <= err_count + 1'b1;
    end
  end
`else
  assign push      = accept;
  assign err       = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios followed by a
// randomized run, compared every cycle against a queue-based reference model.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    opcode = '0;
  logic [4:0]    rd = '0;
  logic [4:0]    rs1 = '0;
  logic [4:0]    rs2 = '0;
  logic [2:0]    func3 = '0;
  logic [6:0]    func7 = '0;
  logic [31:0]   imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [7:0]    err_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] q[$];
  logic [31:0] addr_m = '0;
  logic        err_m = 1'b0;
  int unsigned cnt_m = 0;

  instr_encoder #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .func3    (func3),
    .func7    (func7),
    .imm      (imm),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_addr (out_addr),
    .err      (err),
    .err_count(err_count)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic longint unsigned p2(input int unsigned n);
    return 64'd1 << n;
  endfunction

  function automatic longint unsigned fld(input longint unsigned v, input int unsigned lo,
                                          input int unsigned n);
    return (v / p2(lo)) % p2(n);
  endfunction

  function automatic byte kind(input logic [6:0] op);
    case (op)
      7'h33:                      return "R";
      7'h13, 7'h03, 7'h67, 7'h73: return "I";
      7'h23:                      return "S";
      7'h63:                      return "B";
      7'h37, 7'h17:               return "U";
      7'h6F:                      return "J";
      default:                    return "X";
    endcase
  endfunction

  // Reference encoding built from the format tables with place-value arithmetic.
  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] im);
    longint unsigned r;
    longint unsigned i = im;
    longint unsigned base_rs = s1 * p2(15) + f3 * p2(12);
    case (kind(op))
      "I": r = fld(i, 0, 12) * p2(20) + base_rs + d * p2(7);
      "S": r = fld(i, 5, 7) * p2(25) + s2 * p2(20) + base_rs + fld(i, 0, 5) * p2(7);
      "B": r = fld(i, 12, 1) * p2(31) + fld(i, 5, 6) * p2(25) + s2 * p2(20) + base_rs
             + fld(i, 1, 4) * p2(8) + fld(i, 11, 1) * p2(7);
      "U": r = fld(i, 12, 20) * p2(12) + d * p2(7);
      "J": r = fld(i, 20, 1) * p2(31) + fld(i, 1, 10) * p2(21) + fld(i, 11, 1) * p2(20)
             + fld(i, 12, 8) * p2(12) + d * p2(7);
      default: r = f7 * p2(25) + s2 * p2(20) + base_rs + d * p2(7);
    endcase
    r = r + op;
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare outputs with the model, advance one clock, then update the model.
  task automatic cycle();
    bit fire_in;
    bit fire_out;
    bit legal;
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_instr", out_instr, q[0]);
      chk("out_addr", out_addr, addr_m);
    end
    chk("err", {31'd0, err}, {31'd0, err_m});
    chk("err_count", {24'd0, err_count}, cnt_m);
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    legal    = kind(opcode) != "X";
    @(posedge clk);
    if (rst) begin
      q.delete();
      addr_m = '0;
      err_m  = 1'b0;
      cnt_m  = 0;
    end else begin
      if (fire_out && q.size() != 0) void'(q.pop_front());
      if (start) addr_m = base_addr & ~32'd3;
      else if (fire_out && !flush) addr_m = addr_m + 32'd4;
      err_m = CHK && fire_in && !legal;
      if (err_m && cnt_m < 255) cnt_m++;
      if (flush) q.delete();
      else if (fire_in && (legal || !CHK)) q.push_back(enc(opcode, rd, rs1, rs2, func3, func7, imm));
    end
    #1;
  endtask

  task automatic set_tuple(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1; base_addr = b;
    cycle();
    start = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bit f;
      f = in_valid && in_ready;
      cycle();
      if (f) in_valid = 1'b0;
      if (!in_valid && q.size() == 0) break;
    end
    out_ready = 1'b0;
    chk("drained", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] head;
    logic [6:0]  legal_ops [10];
    legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);

    // add x3,x1,x2 at 0x100, visible one cycle after acceptance
    do_start(32'h100);
    set_tuple(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_word", out_instr, 32'h002081B3);
    chk("add_addr", out_addr, 32'h100);
    drain();

    // addi then sw, back to back
    do_start(32'h100);
    in_valid = 1'b1;
    set_tuple(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    cycle();
    set_tuple(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
    cycle();
    in_valid = 1'b0;
    chk("addi_word", out_instr, 32'h00500093);
    chk("addi_addr", out_addr, 32'h100);
    out_ready = 1'b1;
    cycle();
    chk("sw_word", out_instr, 32'h0020A423);
    chk("sw_addr", out_addr, 32'h104);
    drain();

    // beq with negative offset, lui
    in_valid = 1'b1;
    set_tuple(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    cycle();
    set_tuple(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    cycle();
    in_valid = 1'b0;
    chk("beq_word", out_instr, 32'hFE000EE3);
    out_ready = 1'b1;
    cycle();
    chk("lui_word", out_instr, 32'h123452B7);
    drain();

    // Backpressure: four fill the FIFO, the fifth waits
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_tuple(7'b0010011, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k * 3));
      cycle();
    end
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    set_tuple(7'b0010011, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd99);
    head = out_instr;
    cycle();
    cycle();
    chk("full_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("full_hold_word", out_instr, head);
    drain();

    // Flush with three words buffered; head address is retained
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_tuple(7'b0110111, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k) << 12);
      cycle();
    end
    in_valid = 1'b0;
    head = out_addr;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("flush_empty", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    set_tuple(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000FF7FE);
    cycle();
    in_valid = 1'b0;
    chk("flush_addr", out_addr, head);
    drain();

    // Unknown opcode 0000000
    in_valid = 1'b1;
    set_tuple(7'b0000000, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    cycle();
    in_valid = 1'b0;
`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
    chk("bad_err", {31'd0, err}, 32'd1);
    chk("bad_count", {24'd0, err_count}, 32'd1);
    chk("bad_dropped", {31'd0, out_valid}, 32'd0);
`else
    chk("bad_word", out_instr, 32'h00208180);
`endif
    drain();

    // Address wrap past the top of the space
    do_start(32'hFFFF_FFFF);
    in_valid = 1'b1;
    set_tuple(7'b0010111, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
    cycle();
    cycle();
    in_valid = 1'b0;
    chk("wrap_addr0", out_addr, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    cycle();
    chk("wrap_addr1", out_addr, 32'h0);
    drain();

`ifdef INSTR_ENCODER_ILLEGAL_CHECK_EN
    // Saturation of the dropped-tuple counter
    in_valid = 1'b1;
    set_tuple(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int k = 0; k < 260; k++) cycle();
    in_valid = 1'b0;
    cycle();
    chk("sat_count", {24'd0, err_count}, 32'd255);
`endif

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      in_valid  = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 40) == 0;
      start     = $urandom_range(0, 30) == 0;
      base_addr = $urandom;
      set_tuple(($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 9)],
                5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), $urandom);
      cycle();
    end
    flush = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    drain();

    // Reset mid-stream
    in_valid = 1'b1;
    set_tuple(7'b0110011, 5'd4, 5'd5, 5'd6, 3'd1, 7'h20, 32'd0);
    cycle();
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_addr", out_addr, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_count", {24'd0, err_count}, 32'd0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
